// File: rtl/tile_pkg.sv
// tile_pkg
//   Shared definitions for the background tile map: map geometry, the tile
//   command opcodes, the bit layout of a tile-map entry (also used by the
//   background renderer) and the writer FSM state encoding.
package tile_pkg;

    localparam int TILE_COLS = 40;                      // 640 / 16
    localparam int TILE_ROWS = 30;                      // 480 / 16
    localparam int MAP_WORDS = TILE_COLS * TILE_ROWS;   // 1200

    typedef enum logic [1:0] {
        OP_SINGLE = 2'd0,
        OP_RECT   = 2'd1,
        OP_CLEAR  = 2'd2,
        OP_RSVD   = 2'd3
    } cmd_op_e;

    // Tile-map entry layout
    localparam int ENTRY_SHEET_COL_LSB = 0;
    localparam int ENTRY_SHEET_COL_W   = 3;
    localparam int ENTRY_SHEET_ROW_LSB = 3;
    localparam int ENTRY_SHEET_ROW_W   = 3;
    localparam int ENTRY_XFLIP_BIT     = 6;
    localparam int ENTRY_YFLIP_BIT     = 7;
    localparam int ENTRY_ENABLE_BIT    = 8;

    // Bits above the enable flag are reserved and always written as zero.
    localparam logic [15:0] ENTRY_USED_MASK = 16'((1 << (ENTRY_ENABLE_BIT + 1)) - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } wr_state_e;

endpackage

// File: rtl/tile_rect_walker.sv
// tile_rect_walker
//   Row-major walker over a clipped rectangle of the tile map. Produces the
//   current tile RAM address incrementally (no multiplier in the loop).
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   load          capture base address and extent (w, h both non-zero when used)
//   step          advance to the next tile of the rectangle
//   base          row*TILE_COLS + col of the top-left tile
//   w, h          clipped rectangle extent in tiles
//   addr          address of the current tile
//   last          current tile is the final one of the rectangle
module tile_rect_walker
    import tile_pkg::*;
#(
    parameter int TILE_COLS = tile_pkg::TILE_COLS,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [5:0]        w,
    input  logic [4:0]        h,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [5:0]        w_q;
    logic [5:0]        col_left;
    logic [4:0]        row_left;
    logic [ADDR_W-1:0] row_skip;

    // From the last tile of one row to the first tile of the next.
    assign row_skip = ADDR_W'(TILE_COLS + 1) - ADDR_W'(w_q);
    assign last     = (col_left == '0) && (row_left == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            w_q      <= '0;
            col_left <= '0;
            row_left <= '0;
        end else if (load) begin
            addr     <= base;
            w_q      <= w;
            col_left <= w - 6'd1;
            row_left <= h - 5'd1;
        end else if (step) begin
            if (col_left == '0) begin
                col_left <= w_q - 6'd1;
                row_left <= row_left - 5'd1;
                addr     <= addr + row_skip;
            end else begin
                col_left <= col_left - 6'd1;
                addr     <= addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/tile_map_writer.sv
// tile_map_writer
//   Write-side engine for the 40x30 background tile map. Accepts single-tile,
//   clipped rectangle-fill and clear-all commands and issues one RAM write per
//   cycle in which wr_allow (vblank) is high.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready decoded from state)
//   cmd_op                0 single, 1 rect, 2 clear all, 3 reserved no-op
//   cmd_col, cmd_row      start tile
//   cmd_w, cmd_h          rect extent (rect only)
//   cmd_data              tile entry, bits [15:9] dropped
//   wr_allow              writes permitted this cycle
//   ram_we/addr/wdata     registered tile RAM write port
//   busy                  command in progress
//   done                  one-cycle completion pulse
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | cmd_ready high, waiting for a command
// RUN     | issuing writes on wr_allow; leaves once all writes are out
// DONE    | done pulse cycle, cmd_ready still low
module tile_map_writer
    import tile_pkg::*;
#(
    parameter int TILE_COLS = tile_pkg::TILE_COLS,
    parameter int TILE_ROWS = tile_pkg::TILE_ROWS,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [5:0]        cmd_col,
    input  logic [4:0]        cmd_row,
    input  logic [5:0]        cmd_w,
    input  logic [4:0]        cmd_h,
    input  logic [15:0]       cmd_data,
    input  logic              wr_allow,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    output logic              busy,
    output logic              done
);

    wr_state_e         state;
    logic              run_active;
    logic [15:0]       data_q;

    logic [5:0]        acc_col, acc_w, w_eff;
    logic [4:0]        acc_row, acc_h, h_eff;
    logic [15:0]       acc_data;
    logic [ADDR_W-1:0] acc_base;
    logic              extent_zero;
    int                col_room, row_room;

    logic              walk_load, walk_step, walk_last;
    logic [ADDR_W-1:0] walk_addr;

    assign cmd_ready = (state == ST_IDLE);

    // Normalise the incoming command to a (col, row, w, h, data) rectangle and
    // clip it against the map edge.
    always_comb begin
        acc_col  = cmd_col;
        acc_row  = cmd_row;
        acc_w    = cmd_w;
        acc_h    = cmd_h;
        acc_data = cmd_data & ENTRY_USED_MASK;
        case (cmd_op)
            OP_SINGLE: begin
                acc_w = 6'd1;
                acc_h = 5'd1;
            end
            OP_RECT: begin
            end
            OP_CLEAR: begin
                acc_col  = '0;
                acc_row  = '0;
                acc_w    = 6'(TILE_COLS);
                acc_h    = 5'(TILE_ROWS);
                acc_data = '0;
            end
            default: begin
                acc_w = '0;
                acc_h = '0;
            end
        endcase
        col_room = TILE_COLS - int'(acc_col);
        row_room = TILE_ROWS - int'(acc_row);
        w_eff    = '0;
        h_eff    = '0;
        if (col_room > 0 && row_room > 0) begin
            w_eff = (int'(acc_w) < col_room) ? acc_w : 6'(col_room);
            h_eff = (int'(acc_h) < row_room) ? acc_h : 5'(row_room);
        end
        extent_zero = (w_eff == '0) || (h_eff == '0);
        acc_base    = ADDR_W'(int'(acc_row) * TILE_COLS + int'(acc_col));
    end

    assign walk_load = (state == ST_IDLE) && cmd_valid;
    assign walk_step = (state == ST_RUN) && run_active && wr_allow;

    tile_rect_walker #(
        .TILE_COLS (TILE_COLS),
        .ADDR_W    (ADDR_W)
    ) u_walker (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (walk_load),
        .step  (walk_step),
        .base  (acc_base),
        .w     (w_eff),
        .h     (h_eff),
        .addr  (walk_addr),
        .last  (walk_last)
    );

    // A zero-extent command still passes through RUN for one cycle with no
    // writes pending, so its done pulse lands one cycle after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            run_active <= 1'b0;
            data_q     <= '0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state      <= ST_RUN;
                        busy       <= 1'b1;
                        run_active <= !extent_zero;
                        data_q     <= acc_data;
                    end
                end
                ST_RUN: begin
                    if (run_active) begin
                        if (wr_allow) begin
                            ram_we    <= 1'b1;
                            ram_addr  <= walk_addr;
                            ram_wdata <= data_q;
                            if (walk_last) begin
                                run_active <= 1'b0;
                            end
                        end
                    end else begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    run_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_map_writer.sv
// tb_tile_map_writer
//   Bench for tile_map_writer. The reference model expands each accepted
//   command into the list of (address, data) writes it must produce, walking
//   the map tile by tile and skipping anything outside 40x30.
module tb_tile_map_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = '0;
    logic [5:0]  cmd_col = '0;
    logic [4:0]  cmd_row = '0;
    logic [5:0]  cmd_w = '0;
    logic [4:0]  cmd_h = '0;
    logic [15:0] cmd_data = '0;
    logic        wr_allow = 1'b0;
    logic        cmd_ready, ram_we, busy, done;
    logic [15:0] ram_addr, ram_wdata;

    always #5 clk = ~clk;

    tile_map_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_col   (cmd_col),
        .cmd_row   (cmd_row),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_data  (cmd_data),
        .wr_allow  (wr_allow),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .busy      (busy),
        .done      (done)
    );

    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;
    int          pend_cmds = 0;
    int          wa_mode = 0;
    logic        wa_at_edge = 1'b0;

    int          exp_addr[$];
    logic [15:0] exp_data[$];
    int          seen_addr[$];
    logic [15:0] seen_data[$];
    int          acc_cyc[$];
    int          done_cyc[$];
    int          we_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Expand a command into the writes it must produce.
    task automatic model_accept();
        int c0, r0, ww, hh;
        logic [15:0] d;
        c0 = int'(cmd_col);
        r0 = int'(cmd_row);
        ww = int'(cmd_w);
        hh = int'(cmd_h);
        d  = {7'b0, cmd_data[8:0]};
        case (cmd_op)
            2'd0: begin ww = 1; hh = 1; end
            2'd1: begin end
            2'd2: begin c0 = 0; r0 = 0; ww = 40; hh = 30; d = 16'h0000; end
            default: begin ww = 0; hh = 0; end
        endcase
        for (int r = r0; r < r0 + hh && r < 30; r++) begin
            for (int c = c0; c < c0 + ww && c < 40; c++) begin
                exp_addr.push_back(r * 40 + c);
                exp_data.push_back(d);
            end
        end
        pend_cmds++;
    endtask

    always @(posedge clk) begin
        cycle++;
        wa_at_edge = wr_allow;
        if (rst_n && cmd_valid && cmd_ready) begin
            model_accept();
            acc_cyc.push_back(cycle);
        end
    end

    always @(posedge clk) begin
        #1;
        case (wa_mode)
            0:       wr_allow = 1'b1;
            1:       wr_allow = ~wr_allow;
            default: wr_allow = ($urandom_range(0, 3) != 0);
        endcase
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_is_not_busy", cmd_ready, !busy);
            if (ram_we) begin
                chk("we_only_when_allowed", wa_at_edge, 1);
                if (exp_addr.size() == 0) begin
                    chk("unexpected_write_addr", ram_addr, 16'hFFFF);
                end else begin
                    chk("write_addr", ram_addr, exp_addr[0]);
                    chk("write_data", ram_wdata, exp_data[0]);
                    void'(exp_addr.pop_front());
                    void'(exp_data.pop_front());
                end
                seen_addr.push_back(int'(ram_addr));
                seen_data.push_back(ram_wdata);
                we_cyc.push_back(cycle);
            end
            if (done) begin
                chk("ready_low_in_done", cmd_ready, 0);
                chk("writes_complete_at_done", exp_addr.size(), 0);
                chk("done_has_command", pend_cmds > 0, 1);
                if (pend_cmds > 0) pend_cmds--;
                done_cyc.push_back(cycle);
            end
        end
    end

    task automatic send(input logic [1:0] op, input int col, input int row,
                        input int w, input int h, input logic [15:0] data);
        int g = 0;
        @(posedge clk); #1;
        cmd_op    = op;
        cmd_col   = 6'(col);
        cmd_row   = 5'(row);
        cmd_w     = 6'(w);
        cmd_h     = 5'(h);
        cmd_data  = data;
        cmd_valid = 1'b1;
        while (!cmd_ready && g < 5000) begin
            @(posedge clk); #1;
            g++;
        end
        chk("send_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int g = 0;
        while ((pend_cmds != 0 || !cmd_ready) && g < limit) begin
            @(posedge clk); #1;
            g++;
        end
        chk("idle_reached", (pend_cmds == 0) && cmd_ready, 1);
    endtask

    task automatic clear_logs();
        seen_addr.delete();
        seen_data.delete();
        acc_cyc.delete();
        done_cyc.delete();
        we_cyc.delete();
    endtask

    task automatic run_one(input logic [1:0] op, input int col, input int row,
                           input int w, input int h, input logic [15:0] data,
                           output int n_we, output int t_we0, output int t_done);
        clear_logs();
        send(op, col, row, w, h, data);
        wait_idle(5000);
        n_we   = seen_addr.size();
        t_we0  = (we_cyc.size() > 0 && acc_cyc.size() > 0) ? we_cyc[0] - acc_cyc[0] : -1;
        t_done = (done_cyc.size() > 0 && acc_cyc.size() > 0) ? done_cyc[0] - acc_cyc[0] : -1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, tw, td, g;

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;

        // Single write
        wa_mode = 0;
        run_one(2'd0, 3, 2, 0, 0, 16'h01AB, n, tw, td);
        chk("single_count", n, 1);
        chk("single_addr", seen_addr[0], 83);
        chk("single_data", seen_data[0], 16'h01AB);
        chk("single_we_latency", tw, 1);
        chk("single_done_latency", td, 2);

        // Single write in the corner with reserved data bits set
        run_one(2'd0, 39, 29, 7, 3, 16'hFE55, n, tw, td);
        chk("corner_count", n, 1);
        chk("corner_addr", seen_addr[0], 1199);
        chk("corner_data_masked", seen_data[0], 16'h0055);

        // Rect clipped at the bottom-right corner
        run_one(2'd1, 38, 28, 4, 4, 16'h0105, n, tw, td);
        chk("clip_count", n, 4);
        chk("clip_addr0", seen_addr[0], 1158);
        chk("clip_addr1", seen_addr[1], 1159);
        chk("clip_addr2", seen_addr[2], 1198);
        chk("clip_addr3", seen_addr[3], 1199);
        chk("clip_done_latency", td, 5);

        // Clear all with wr_allow toggling every cycle
        wa_mode = 1;
        run_one(2'd2, 5, 5, 1, 1, 16'hFFFF, n, tw, td);
        chk("clear_count", n, 1200);
        chk("clear_first_addr", seen_addr[0], 0);
        chk("clear_last_addr", seen_addr[1199], 1199);
        chk("clear_data", seen_data[600], 16'h0000);

        // Zero-extent commands
        wa_mode = 0;
        run_one(2'd1, 40, 0, 4, 4, 16'h0001, n, tw, td);
        chk("col40_count", n, 0);
        chk("col40_done_latency", td, 1);
        run_one(2'd1, 0, 0, 0, 4, 16'h0001, n, tw, td);
        chk("w0_count", n, 0);
        chk("w0_done_latency", td, 1);
        run_one(2'd3, 1, 1, 4, 4, 16'h0001, n, tw, td);
        chk("rsvd_count", n, 0);
        chk("rsvd_done_latency", td, 1);
        run_one(2'd0, 0, 30, 1, 1, 16'h0001, n, tw, td);
        chk("row30_count", n, 0);
        chk("row30_done_latency", td, 1);

        // Reset in the middle of a 5x5 rect
        clear_logs();
        send(2'd1, 10, 5, 5, 5, 16'h0033);
        g = 0;
        while (seen_addr.size() < 10 && g < 100) begin
            @(negedge clk); #2;
            g++;
        end
        chk("rst_mid_writes_before", seen_addr.size(), 10);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we_low", ram_we, 0);
        chk("rst_mid_busy_low", busy, 0);
        chk("rst_mid_ready_high", cmd_ready, 1);
        exp_addr.delete();
        exp_data.delete();
        pend_cmds = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        chk("rst_mid_no_more_writes", seen_addr.size(), 10);
        run_one(2'd0, 1, 1, 0, 0, 16'h0100, n, tw, td);
        chk("post_rst_count", n, 1);
        chk("post_rst_addr", seen_addr[0], 41);
        chk("post_rst_done_latency", td, 2);

        // cmd_valid held across two commands
        clear_logs();
        @(posedge clk); #1;
        cmd_op = 2'd0; cmd_col = 6'd0; cmd_row = 5'd0; cmd_w = '0; cmd_h = '0;
        cmd_data = 16'h0001; cmd_valid = 1'b1;
        g = 0;
        while (acc_cyc.size() < 1 && g < 50) begin @(posedge clk); #1; g++; end
        cmd_op = 2'd1; cmd_col = 6'd0; cmd_row = 5'd1; cmd_w = 6'd3; cmd_h = 5'd1;
        cmd_data = 16'h0002;
        g = 0;
        while (acc_cyc.size() < 2 && g < 50) begin @(posedge clk); #1; g++; end
        cmd_valid = 1'b0;
        wait_idle(200);
        chk("b2b_accepts", acc_cyc.size(), 2);
        chk("b2b_gap_after_done", (acc_cyc.size() > 1 && done_cyc.size() > 0) ? acc_cyc[1] - done_cyc[0] : -1, 2);
        chk("b2b_writes", seen_addr.size(), 4);

        // Randomised commands under random / toggling wr_allow
        for (int i = 0; i < 60; i++) begin
            int r;
            logic [1:0] op;
            wa_mode = ($urandom_range(0, 3) == 0) ? 1 : 2;
            r = $urandom_range(0, 39);
            if (r < 14)      op = 2'd0;
            else if (r < 36) op = 2'd1;
            else if (r < 38) op = 2'd3;
            else if (r == 38 && i % 20 == 0) op = 2'd2;
            else             op = 2'd1;
            send(op, $urandom_range(0, 45), $urandom_range(0, 33),
                 $urandom_range(0, 12), $urandom_range(0, 8), 16'($urandom));
            if ($urandom_range(0, 1) == 1) wait_idle(5000);
        end
        wait_idle(5000);
        chk("final_queue_empty", exp_addr.size(), 0);
        chk("final_no_pending", pend_cmds, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
